// File: rtl/riscv_mc_control_pkg.sv
// Shared RV32I types for the multicycle core: instruction kinds, formats,
// datapath control word, control FSM states and classification helpers.
package riscv_mc_control_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
    SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU,
    XOR, SRL, SRA, OR, AND,
    FENCE, FENCEI, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC,
    CSRRWI, CSRRSI, CSRRCI, WFI
  } inst_type;

  typedef enum logic [2:0] {
    R_type, I_type, S_type,
    B_type, U_type, J_type
  } fmts;

  typedef struct packed {
    logic CY1;
    logic CY2;
    logic walu;
    logic wmdr;
    logic wpc;
    logic wreg;
    logic whilo;
    logic ce;
    logic rw;
    logic bw;
    logic i;
    logic rst_md;
  } microinstruction;

  localparam microinstruction UINS_NOP = '0;

  typedef enum logic [2:0] {
    INIT, FETCH, DECODE, EXEC,
    MEM, WB, HALT
  } ctrl_state;

  function automatic logic is_load(
    input inst_type t
  );
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(
    input inst_type t
  );
    return t inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/riscv_mc_control_mem_wait_timer.sv
// Memory wait counter: counts not-ready cycles of an access (active) and
// flags timeout when the count reaches WAIT_LIMIT with mem_ready still low.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt <= '0;
    else if (active && !mem_ready)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  assign timeout = active && !mem_ready
                && (cnt == CW'(WAIT_LIMIT));

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control FSM: drives uins per cycle, stalls on mem_ready,
// halts on ECALL/EBREAK/timeout; outputs halted, bus_error, retired, state_dbg.
module riscv_mc_control
  import riscv_mc_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int RET_W      = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  inst_type        i_type,
  input  fmts             i_fmt,
  input  logic            branch_taken,
  input  logic            mem_ready,
  output microinstruction uins,
  output logic            halted,
  output logic            bus_error,
  output logic [RET_W-1:0] retired,
  output logic [2:0]      state_dbg
);

  ctrl_state       state, nstate;
  inst_type        type_q;
  fmts             fmt_q;
  microinstruction u;
  logic            retire, to_err;
  logic            timeout, waiting;

  assign waiting = (state == FETCH)
                || (state == MEM);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .active   (waiting),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= INIT;
      retired   <= '0;
      bus_error <= 1'b0;
      type_q    <= LUI;
      fmt_q     <= R_type;
    end else begin
      state <= nstate;
      if (retire)
        retired <= retired + RET_W'(1);
      if (to_err)
        bus_error <= 1'b1;
      if (state == DECODE) begin
        type_q <= i_type;
        fmt_q  <= i_fmt;
      end
    end
  end

  always_comb begin
    nstate = state;
    u      = UINS_NOP;
    retire = 1'b0;
    to_err = 1'b0;
    unique case (state)
      INIT: begin
        u.rst_md = 1'b1;
        nstate   = FETCH;
      end
      FETCH: begin
        u.ce = 1'b1;
        u.rw = 1'b1;
        u.bw = 1'b1;
        if (mem_ready) begin
          u.CY1  = 1'b1;
          u.wpc  = 1'b1;
          nstate = DECODE;
        end else if (timeout) begin
          nstate = HALT;
          to_err = 1'b1;
        end
      end
      DECODE: begin
        u.CY2 = 1'b1;
        if (i_type inside {ECALL, EBREAK})
          nstate = HALT;
        else if (i_type inside {FENCE, FENCEI, WFI}) begin
          nstate = FETCH;
          retire = 1'b1;
        end else
          nstate = EXEC;
      end
      EXEC: begin
        u.walu = 1'b1;
        u.i    = fmt_q inside {I_type, U_type, S_type};
        if (fmt_q == B_type) begin
          u.wpc  = branch_taken;
          nstate = FETCH;
          retire = 1'b1;
        end else if (type_q inside {JAL, JALR}) begin
          u.wpc  = 1'b1;
          nstate = WB;
        end else if (is_load(type_q) || is_store(type_q))
          nstate = MEM;
        else
          nstate = WB;
      end
      MEM: begin
        u.ce = 1'b1;
        u.rw = is_load(type_q);
        u.bw = type_q inside {LW, SW};
        if (mem_ready) begin
          if (is_load(type_q)) begin
            u.wmdr = 1'b1;
            nstate = WB;
          end else begin
            nstate = FETCH;
            retire = 1'b1;
          end
        end else if (timeout) begin
          nstate = HALT;
          to_err = 1'b1;
        end
      end
      WB: begin
        u.wreg = 1'b1;
        nstate = FETCH;
        retire = 1'b1;
      end
      HALT: nstate = HALT;
      default: nstate = INIT;
    endcase
  end

  // Reset kills the control word at once, so an in-flight access is dropped
  // in the cycle reset is asserted rather than one edge later.
  assign uins      = reset_n ? u : UINS_NOP;
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule
